cozy_uart: RTL and testbench

- Memory-mapped UART peripheral on the cozy CPU data bus. Sits directly downstream of cozy_cpu, beside cozy_memory_sim.
- Decodes an 8-byte window of the 16-bit address space.
- Provides an 8-deep TX FIFO, a single RX holding register, a programmable bit divisor and sticky status flags.
- The top level muxes bus_dout into the CPU's mem_din whenever bus_sel is high.

---
 rtl/cozy_uart_pkg.sv | 38 +++
 rtl/cozy_fifo.sv | 50 +++++
 rtl/cozy_uart.sv | 270 +++++++++++++++++++++++++++
 tb/tb_cozy_uart.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cozy_uart_pkg.sv
// Shared definitions for the cozy UART: register indices, STATUS bit positions,
// FSM state types and the divisor clamp.
package cozy_uart_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DIV    = 2'd2;
  localparam logic [1:0] REG_RXACK  = 2'd3;

  localparam int unsigned ST_RX_VALID = 0;
  localparam int unsigned ST_RX_OVR   = 1;
  localparam int unsigned ST_RX_FERR  = 2;
  localparam int unsigned ST_TX_FULL  = 3;
  localparam int unsigned ST_TX_EMPTY = 4;
  localparam int unsigned ST_TX_IDLE  = 5;
  localparam int unsigned ST_TX_OVF   = 6;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_t;

  // A bit period below two clocks would break the half-bit RX sample point.
  function automatic logic [15:0] eff_div(input logic [15:0] d);
    return (d < 16'd2) ? 16'd2 : d;
  endfunction

endpackage

// File: rtl/cozy_fifo.sv
// Synchronous FIFO with occupancy count; a push while full is accepted only
// when a pop happens on the same edge.
module cozy_fifo #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned FIFO_AW = 3
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               push,
  input  logic               pop,
  input  logic [WIDTH-1:0]   din,
  output logic [WIDTH-1:0]   dout,
  output logic               full,
  output logic               empty,
  output logic [FIFO_AW:0]   count
);

  logic [WIDTH-1:0]   mem [2**FIFO_AW];
  logic [FIFO_AW-1:0] wp;
  logic [FIFO_AW-1:0] rp;
  logic               do_push;
  logic               do_pop;

  assign full    = count[FIFO_AW];
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rp];

  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= din;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/cozy_uart.sv
// Memory-mapped UART for the cozy CPU bus: 8-deep TX FIFO, single RX holding
// register, programmable bit divisor and sticky status flags.
module cozy_uart
  import cozy_uart_pkg::*;
#(
  parameter logic [15:0] BASE        = 16'hff00,
  parameter logic [15:0] DEFAULT_DIV = 16'd434,
  parameter int unsigned FIFO_AW     = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] bus_addr,
  input  logic [1:0]  bus_bwe,
  input  logic [15:0] bus_din,
  output logic [15:0] bus_dout,
  output logic        bus_sel,
  output logic        uart_tx,
  input  logic        uart_rx
);

  logic        hit;
  logic [1:0]  idx;
  logic        wr;
  logic        data_wr;
  logic        stat_wr;
  logic        div_wr;
  logic        ack_wr;
  logic        unused_addr0;

  assign hit          = (bus_addr[15:3] == BASE[15:3]);
  assign idx          = bus_addr[2:1];
  assign wr           = hit && (bus_bwe != 2'b00);
  assign data_wr      = wr && (idx == REG_DATA) && bus_bwe[0];
  assign stat_wr      = wr && (idx == REG_STATUS) && bus_bwe[0];
  assign div_wr       = wr && (idx == REG_DIV);
  assign ack_wr       = wr && (idx == REG_RXACK);
  assign unused_addr0 = bus_addr[0];

  logic [15:0] div;
  logic [15:0] bit_per;

  assign bit_per = eff_div(div);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div <= DEFAULT_DIV;
    end else if (div_wr) begin
      if (bus_bwe[1]) div[15:8] <= bus_din[15:8];
      if (bus_bwe[0]) div[7:0]  <= bus_din[7:0];
    end
  end

  logic              fifo_full;
  logic              fifo_empty;
  logic [FIFO_AW:0]  fifo_count;
  logic [7:0]        fifo_dout;
  logic              tx_pop;

  cozy_fifo #(
    .WIDTH   (8),
    .FIFO_AW (FIFO_AW)
  ) u_txfifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (data_wr),
    .pop     (tx_pop),
    .din     (bus_din[7:0]),
    .dout    (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  tx_state_t   tx_state;
  tx_state_t   tx_nxt;
  logic [15:0] tx_cnt;
  logic [2:0]  tx_bit;
  logic [7:0]  tx_shift;
  logic        tx_tick;
  logic        tx_line;

  assign tx_tick = (tx_cnt == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) tx_state <= TX_IDLE;
    else          tx_state <= tx_nxt;
  end

  always_comb begin
    tx_nxt = tx_state;
    tx_pop = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        if (!fifo_empty) begin
          tx_nxt = TX_START;
          tx_pop = 1'b1;
        end
      end
      TX_START: if (tx_tick) tx_nxt = TX_DATA;
      TX_DATA:  if (tx_tick && tx_bit == 3'd7) tx_nxt = TX_STOP;
      TX_STOP: begin
        if (tx_tick) begin
          if (!fifo_empty) begin
            tx_nxt = TX_START;
            tx_pop = 1'b1;
          end else begin
            tx_nxt = TX_IDLE;
          end
        end
      end
      default: tx_nxt = TX_IDLE;
    endcase
  end

  // Line level for the upcoming cycle so uart_tx can be a plain register.
  always_comb begin
    tx_line = 1'b1;
    case (tx_nxt)
      TX_START: tx_line = 1'b0;
      TX_DATA:  tx_line = (tx_state == TX_DATA && tx_tick) ? tx_shift[1] : tx_shift[0];
      default:  tx_line = 1'b1;
    endcase
  end

  // The period is reloaded only at bit boundaries, so DIV writes apply to the next bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      uart_tx  <= 1'b1;
    end else begin
      uart_tx <= tx_line;
      if (tx_pop)
        tx_shift <= fifo_dout;
      else if (tx_state == TX_DATA && tx_tick)
        tx_shift <= tx_shift >> 1;
      if (tx_state != tx_nxt || (tx_state == TX_DATA && tx_tick))
        tx_cnt <= bit_per - 16'd1;
      else if (!tx_tick)
        tx_cnt <= tx_cnt - 16'd1;
      if (tx_state == TX_START)
        tx_bit <= '0;
      else if (tx_state == TX_DATA && tx_tick)
        tx_bit <= tx_bit + 3'd1;
    end
  end

  logic        rx_s1;
  logic        rx_s2;
  rx_state_t   rx_state;
  rx_state_t   rx_nxt;
  logic [15:0] rx_cnt;
  logic [2:0]  rx_bit;
  logic [7:0]  rx_shift;
  logic        rx_tick;
  logic        rx_done;
  logic        rx_ferr_set;

  assign rx_tick = (rx_cnt == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_state <= RX_IDLE;
    end else begin
      rx_s1    <= uart_rx;
      rx_s2    <= rx_s1;
      rx_state <= rx_nxt;
    end
  end

  always_comb begin
    rx_nxt = rx_state;
    case (rx_state)
      RX_IDLE:      if (!rx_s2) rx_nxt = RX_START;
      RX_START:     if (rx_tick) rx_nxt = rx_s2 ? RX_IDLE : RX_DATA;
      RX_DATA:      if (rx_tick && rx_bit == 3'd7) rx_nxt = RX_STOP;
      RX_STOP:      if (rx_tick) rx_nxt = rx_s2 ? RX_IDLE : RX_WAIT_HIGH;
      RX_WAIT_HIGH: if (rx_s2) rx_nxt = RX_IDLE;
      default:      rx_nxt = RX_IDLE;
    endcase
  end

  always_comb begin
    rx_done     = (rx_state == RX_STOP) && rx_tick && rx_s2;
    rx_ferr_set = (rx_state == RX_STOP) && rx_tick && !rx_s2;
  end

  // Idle keeps the half-bit count armed so START samples mid start bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      if (rx_state == RX_IDLE)
        rx_cnt <= (bit_per >> 1) - 16'd1;
      else if (rx_tick)
        rx_cnt <= bit_per - 16'd1;
      else
        rx_cnt <= rx_cnt - 16'd1;
      if (rx_state == RX_START)
        rx_bit <= '0;
      else if (rx_state == RX_DATA && rx_tick)
        rx_bit <= rx_bit + 3'd1;
      if (rx_state == RX_DATA && rx_tick)
        rx_shift <= {rx_s2, rx_shift[7:1]};
    end
  end

  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ovr;
  logic       rx_ferr;
  logic       tx_ovf;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_data  <= '0;
      rx_valid <= 1'b0;
      rx_ovr   <= 1'b0;
      rx_ferr  <= 1'b0;
      tx_ovf   <= 1'b0;
    end else begin
      if (rx_done) rx_data <= rx_shift;
      if (rx_done)      rx_valid <= 1'b1;
      else if (ack_wr)  rx_valid <= 1'b0;
      if (rx_done && rx_valid && !ack_wr)  rx_ovr <= 1'b1;
      else if (stat_wr && bus_din[ST_RX_OVR]) rx_ovr <= 1'b0;
      if (rx_ferr_set)                      rx_ferr <= 1'b1;
      else if (stat_wr && bus_din[ST_RX_FERR]) rx_ferr <= 1'b0;
      if (data_wr && fifo_full && !tx_pop)   tx_ovf <= 1'b1;
      else if (stat_wr && bus_din[ST_TX_OVF]) tx_ovf <= 1'b0;
    end
  end

  logic [15:0] status;
  logic [15:0] rd;

  always_comb begin
    status              = '0;
    status[ST_RX_VALID] = rx_valid;
    status[ST_RX_OVR]   = rx_ovr;
    status[ST_RX_FERR]  = rx_ferr;
    status[ST_TX_FULL]  = fifo_full;
    status[ST_TX_EMPTY] = fifo_empty;
    status[ST_TX_IDLE]  = fifo_empty && (tx_state == TX_IDLE);
    status[ST_TX_OVF]   = tx_ovf;
    rd = '0;
    case (idx)
      REG_DATA:   rd = {8'h00, rx_data};
      REG_STATUS: rd = status;
      REG_DIV:    rd = div;
      REG_RXACK:  rd = 16'(fifo_count);
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus_sel  <= 1'b0;
      bus_dout <= '0;
    end else begin
      bus_sel  <= hit;
      bus_dout <= hit ? rd : 16'h0000;
    end
  end

endmodule

// File: tb/tb_cozy_uart.sv
// Randomized self-checking bench for cozy_uart: bus register model, serial
// frame decoder on uart_tx and serial frame generator on uart_rx.
module tb_cozy_uart;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] bus_addr;
  logic [1:0]  bus_bwe;
  logic [15:0] bus_din;
  logic [15:0] bus_dout;
  logic        bus_sel;
  logic        uart_tx;
  logic        uart_rx;

  always #5 clk = ~clk;

  cozy_uart #(
    .BASE        (16'hff00),
    .DEFAULT_DIV (16'd434),
    .FIFO_AW     (3)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus_addr (bus_addr),
    .bus_bwe  (bus_bwe),
    .bus_din  (bus_din),
    .bus_dout (bus_dout),
    .bus_sel  (bus_sel),
    .uart_tx  (uart_tx),
    .uart_rx  (uart_rx)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model state
  logic [15:0] m_div;
  logic [7:0]  m_data;
  logic        m_valid, m_ovr, m_ferr, m_ovf;
  int unsigned m_cnt;

  function automatic logic [15:0] eff(input logic [15:0] d);
    return (d < 16'd2) ? 16'd2 : d;
  endfunction

  function automatic logic [15:0] exp_status(input logic full, input logic empty, input logic idle);
    return {9'd0, m_ovf, idle, empty, full, m_ferr, m_ovr, m_valid};
  endfunction

  function automatic logic [15:0] reg_addr(input int unsigned idx);
    return 16'hff00 | 16'(idx << 1);
  endfunction

  // Bus tasks start and end 1 ns after a rising edge.
  task automatic bus_write(input int unsigned idx, input logic [15:0] d, input logic [1:0] be);
    bus_addr = reg_addr(idx);
    bus_din  = d;
    bus_bwe  = be;
    @(posedge clk); #1;
    bus_bwe  = 2'b00;
    bus_addr = 16'h0000;
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [15:0] d, output logic s);
    bus_addr = a;
    bus_bwe  = 2'b00;
    @(posedge clk); #1;
    d = bus_dout;
    s = bus_sel;
    bus_addr = 16'h0000;
  endtask

  task automatic read_chk(input string tag, input int unsigned idx, input logic [15:0] exp);
    logic [15:0] d;
    logic        s;
    bus_read(reg_addr(idx), d, s);
    check_eq(tag, d, exp);
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // TX line decoder
  logic            mon_on;
  int unsigned     mon_per;
  logic [7:0]      got_q[$];
  int unsigned     t_q[$];

  always begin : tx_mon
    int unsigned per;
    int unsigned t;
    logic [7:0]  b;
    @(negedge uart_tx);
    per = mon_per;
    #1;
    t = cyc;
    repeat (per / 2) @(posedge clk);
    #1;
    if (mon_on) check_eq("tx_start_bit", uart_tx, 1'b0);
    for (int i = 0; i < 8; i++) begin
      repeat (per) @(posedge clk);
      #1;
      b[i] = uart_tx;
    end
    repeat (per) @(posedge clk);
    #1;
    if (mon_on) begin
      check_eq("tx_stop_bit", uart_tx, 1'b1);
      got_q.push_back(b);
      t_q.push_back(t);
    end
  end

  function automatic logic [15:0] pop_got();
    if (got_q.size() == 0) return 16'hffff;
    return {8'h00, got_q.pop_front()};
  endfunction

  task automatic wait_bytes(input int unsigned n, input int unsigned budget);
    int unsigned k = 0;
    while (got_q.size() < n && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    check_eq("tx_frames_seen", 16'(got_q.size()), 16'(n));
  endtask

  task automatic set_div(input logic [15:0] d);
    bus_write(2, d, 2'b11);
    m_div   = d;
    mon_per = eff(d);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input int unsigned per);
    uart_rx = 1'b0;
    repeat (per) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (per) @(posedge clk);
      #1;
    end
    uart_rx = stop;
    repeat (per) @(posedge clk);
    #1;
    uart_rx = 1'b1;
    repeat (2 * per) @(posedge clk);
    #1;
    if (stop) begin
      if (m_valid) m_ovr = 1'b1;
      m_valid = 1'b1;
      m_data  = b;
    end else begin
      m_ferr = 1'b1;
    end
  endtask

  task automatic check_rx(input string tag);
    read_chk({tag, "_data"}, 0, {8'h00, m_data});
    read_chk({tag, "_status"}, 1, exp_status(1'b0, 1'b1, 1'b1));
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation time limit");
  end

  initial begin : main
    logic [15:0] d;
    logic        s;
    logic [7:0]  b;
    logic [7:0]  exp_q[$];
    logic [15:0] divs[5];
    int unsigned lows;

    reset_n  = 1'b0;
    bus_addr = 16'h0000;
    bus_bwe  = 2'b00;
    bus_din  = 16'h0000;
    uart_rx  = 1'b1;
    mon_on   = 1'b1;
    m_div    = 16'd434;
    mon_per  = eff(16'd434);
    m_data   = 8'h00;
    m_valid  = 1'b0;
    m_ovr    = 1'b0;
    m_ferr   = 1'b0;
    m_ovf    = 1'b0;
    m_cnt    = 0;

    // 1: reset state and register decode
    idle(3);
    check_eq("rst_bus_sel", bus_sel, 1'b0);
    check_eq("rst_bus_dout", bus_dout, 16'h0000);
    check_eq("rst_uart_tx", uart_tx, 1'b1);
    reset_n = 1'b1;
    idle(1);
    bus_read(reg_addr(1), d, s);
    check_eq("status_sel", s, 1'b1);
    check_eq("status_reset", d, 16'h0030);
    read_chk("div_reset", 2, 16'd434);
    read_chk("count_reset", 3, 16'h0000);
    bus_read(16'hff08, d, s);
    check_eq("miss_hi_sel", s, 1'b0);
    check_eq("miss_hi_dout", d, 16'h0000);
    bus_read(16'hfeff, d, s);
    check_eq("miss_lo_sel", s, 1'b0);
    bus_read(16'hff07, d, s);
    check_eq("alias_sel", s, 1'b1);
    check_eq("alias_rxack", d, 16'h0000);
    bus_write(2, 16'h5577, 2'b01);
    read_chk("div_lo_byte", 2, 16'h0177);
    bus_write(2, 16'h03aa, 2'b10);
    read_chk("div_hi_byte", 2, 16'h0377);

    // 2: single byte, latency and idle-vs-empty
    set_div(16'd4);
    bus_write(0, 16'h00a5, 2'b11);
    check_eq("tx_lat_edge_n", uart_tx, 1'b1);
    idle(1);
    check_eq("tx_lat_edge_n1", uart_tx, 1'b0);
    read_chk("status_busy", 1, 16'h0010);
    wait_bytes(1, 80);
    check_eq("tx_a5", pop_got(), 16'h00a5);
    idle(4);
    read_chk("status_done", 1, 16'h0030);

    // Random bytes across small divisors, including clamped 0 and 1
    divs = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd7};
    for (int k = 0; k < 5; k++) begin
      b = 8'($urandom);
      set_div(divs[k]);
      got_q.delete();
      bus_write(0, {8'h00, b}, 2'b01);
      wait_bytes(1, 12 * 32'(eff(divs[k])) + 10);
      check_eq("tx_rand", pop_got(), {8'h00, b});
      idle(2 * 32'(eff(divs[k])) + 2);
    end

    // 3: burst of 9 while a byte is on the line; 9th overflows
    set_div(16'd4);
    got_q.delete();
    t_q.delete();
    exp_q.delete();
    b = 8'($urandom);
    exp_q.push_back(b);
    bus_write(0, {8'h00, b}, 2'b11);
    idle(1);
    m_cnt = 0;
    for (int i = 0; i < 9; i++) begin
      b = 8'($urandom);
      if (m_cnt < 8) begin
        exp_q.push_back(b);
        m_cnt++;
      end else begin
        m_ovf = 1'b1;
      end
      bus_write(0, {8'h00, b}, 2'b01);
    end
    read_chk("count_peak", 3, 16'(m_cnt));
    read_chk("status_ovf", 1, exp_status(1'b1, 1'b0, 1'b0));
    wait_bytes(9, 600);
    for (int i = 0; i < 9; i++) check_eq("tx_burst_byte", pop_got(), {8'h00, exp_q[i]});
    for (int i = 0; i + 1 < t_q.size(); i++)
      check_eq("tx_no_gap", 16'(t_q[i + 1] - t_q[i]), 16'd40);
    idle(4);
    bus_write(1, 16'h0040, 2'b11);
    m_ovf = 1'b0;
    read_chk("status_ovf_clr", 1, 16'h0030);

    // 4: receive path
    send_frame(8'h3c, 1'b1, 4);
    check_rx("rx_3c");
    send_frame(8'h81, 1'b1, 4);
    check_rx("rx_81_ovr");
    bus_write(3, 16'h0000, 2'b11);
    m_valid = 1'b0;
    check_rx("rx_ack");
    bus_write(1, 16'h0002, 2'b01);
    m_ovr = 1'b0;
    check_rx("rx_ovr_clr");
    for (int k = 0; k < 6; k++) begin
      if ($urandom_range(0, 2) == 0) begin
        bus_write(3, 16'(32'($urandom)), 2'b10);
        m_valid = 1'b0;
      end
      if ($urandom_range(0, 2) == 0) begin
        bus_write(1, 16'h0006, 2'b01);
        m_ovr  = 1'b0;
        m_ferr = 1'b0;
      end
      send_frame(8'($urandom), ($urandom_range(0, 3) != 0), 4);
      check_rx("rx_rand");
    end

    // 5: glitch is a false start; bad stop sets ferr only
    uart_rx = 1'b0;
    idle(1);
    uart_rx = 1'b1;
    idle(12);
    check_rx("rx_glitch");
    send_frame(8'($urandom), 1'b0, 4);
    check_rx("rx_ferr");
    send_frame(8'($urandom), 1'b1, 4);
    check_rx("rx_after_ferr");

    // 6: reset mid TX frame
    bus_write(0, 16'h0000, 2'b01);
    idle(15);
    mon_on  = 1'b0;
    reset_n = 1'b0;
    #1;
    check_eq("rst_async_tx", uart_tx, 1'b1);
    idle(1);
    reset_n = 1'b1;
    m_div = 16'd434; m_data = 8'h00;
    m_valid = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0; m_ovf = 1'b0;
    read_chk("rst_count", 3, 16'h0000);
    read_chk("rst_div", 2, m_div);
    read_chk("rst_status", 1, exp_status(1'b0, 1'b1, 1'b1));
    read_chk("rst_rxdata", 0, 16'h0000);
    lows = 0;
    repeat (100) begin
      @(posedge clk); #1;
      if (!uart_tx) lows++;
    end
    check_eq("rst_line_quiet", 16'(lows), 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
